// File: rtl/data_sram_resp_if.sv
// ----------------------------------------------------------------------------
// data_sram_resp_if
//   Request/response bus of the data SRAM.
//
//   Signals:
//     data_sram_en     1   access request this cycle
//     data_sram_we     4   byte write strobes, 0 means read
//     data_sram_addr   32  byte address
//     data_sram_wdata  32  write data, byte lanes aligned to the strobes
//     data_sram_rdata  32  read data, one cycle after the request
//
//   Modports:
//     master  - issues requests, receives rdata
//     slave   - the SRAM block
// ----------------------------------------------------------------------------
interface data_sram_resp_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_resp.sv
// ----------------------------------------------------------------------------
// data_sram_resp
//   Word-organised (32-bit) data SRAM with byte write strobes, a one-cycle
//   read-first response, a power-up clear sweep and a sticky out-of-range
//   error flag.
//
//   After reset the block sits in INIT and zeroes one word per cycle; it
//   enters RUN exactly DEPTH cycles later. Requests are ignored in INIT.
//
//   Parameters:
//     ADDR_BASE   byte address of word 0
//     DEPTH_LOG2  log2 of the number of 32-bit words
//
//   Ports:
//     clk         clock, rising edge
//     reset       synchronous, active-high reset
//     sram_bus    data_sram_resp_if.slave request/response bus
//     sram_ready  high in RUN (requests accepted)
//     sram_err    sticky out-of-range flag, cleared only by reset
//     load_cnt    accepted in-range reads, saturating   (DATA_SRAM_STATS_EN)
//     store_cnt   accepted in-range writes, saturating  (DATA_SRAM_STATS_EN)
//
//   Build option:
//     DATA_SRAM_STATS_EN  when defined, adds the load/store counters.
// ----------------------------------------------------------------------------
module data_sram_resp #(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    data_sram_resp_if.slave        sram_bus,
    output logic                   sram_ready,
`ifdef DATA_SRAM_STATS_EN
    output logic [31:0]            load_cnt,
    output logic [31:0]            store_cnt,
`endif
    output logic                   sram_err
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_en;
    logic [3:0]            w_we;
    logic [32:0]           w_offset;
    logic [31:0]           w_word;
    logic [DEPTH_LOG2-1:0] w_index;
    logic                  w_in_range;
    logic                  w_access;
    logic                  w_rd_hit;
    logic                  w_wr_hit;
    logic                  w_oor;

    assign w_en = sram_bus.data_sram_en;
    assign w_we = sram_bus.data_sram_we;

    // Subtract in 33 bits so bit 32 is the borrow: an address below
    // ADDR_BASE wraps and must be treated as out of range.
    assign w_offset   = {1'b0, sram_bus.data_sram_addr} - {1'b0, ADDR_BASE};
    assign w_word     = w_offset[31:0] >> 2;
    assign w_index    = w_word[DEPTH_LOG2-1:0];
    assign w_in_range = !w_offset[32] && (w_word[31:DEPTH_LOG2] == '0);

    // Reset wins over any request in the same cycle.
    assign w_access = !reset && (r_state == ST_RUN) && w_en;
    assign w_rd_hit = w_access && (w_we == 4'b0000) && w_in_range;
    assign w_wr_hit = w_access && (w_we != 4'b0000) && w_in_range;
    assign w_oor    = w_access && !w_in_range;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the next-state signal gets its default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT: if (&r_idx) w_state_next = ST_RUN;
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_INIT;
        endcase
    end

    // Clear-sweep index; it wraps back to 0 on the last word, which is
    // where a later reset expects to restart from anyway.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
        end else if (r_state == ST_INIT) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // NOTE: the array itself has no reset; the INIT sweep zeroes it, which
    // keeps it mappable onto a plain single-port RAM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_INIT) begin
                r_mem[r_idx] <= '0;
            end else if (w_wr_hit) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_we[i]) begin
                        r_mem[w_index][8*i +: 8] <= sram_bus.data_sram_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // Read-first: a write also returns the word as it was before the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_rd_hit || w_wr_hit) begin
            r_rdata <= r_mem[w_index];
        end else if (w_oor) begin
            r_rdata <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_oor) begin
            r_err <= 1'b1;
        end
    end

`ifdef DATA_SRAM_STATS_EN
    logic [31:0] r_load_cnt;
    logic [31:0] r_store_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_cnt  <= '0;
            r_store_cnt <= '0;
        end else begin
            if (w_rd_hit && (r_load_cnt != '1)) begin
                r_load_cnt <= r_load_cnt + 32'd1;
            end
            if (w_wr_hit && (r_store_cnt != '1)) begin
                r_store_cnt <= r_store_cnt + 32'd1;
            end
        end
    end

    assign load_cnt  = r_load_cnt;
    assign store_cnt = r_store_cnt;
`endif

    assign sram_bus.data_sram_rdata = r_rdata;
    assign sram_ready               = (r_state == ST_RUN);
    assign sram_err                 = r_err;

endmodule

// File: tb/tb_data_sram_resp.sv
// ----------------------------------------------------------------------------
// tb_data_sram_resp
//   Scoreboard bench for data_sram_resp. Each driven cycle runs a
//   behavioural model of the SRAM and pushes the expected post-edge outputs
//   into a queue; an independent monitor pops one entry per clock and
//   compares it against the DUT.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_sram_resp;

    localparam logic [31:0] ADDR_BASE  = 32'h0000_0000;
    localparam int          DEPTH_LOG2 = 10;
    localparam int          DEPTH      = 1 << DEPTH_LOG2;

    logic clk = 1'b0;
    logic reset;
    logic sram_ready;
    logic sram_err;
`ifdef DATA_SRAM_STATS_EN
    logic [31:0] load_cnt;
    logic [31:0] store_cnt;
`endif

    data_sram_resp_if u_bus ();

    data_sram_resp #(
        .ADDR_BASE  (ADDR_BASE),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sram_bus   (u_bus),
        .sram_ready (sram_ready),
`ifdef DATA_SRAM_STATS_EN
        .load_cnt   (load_cnt),
        .store_cnt  (store_cnt),
`endif
        .sram_err   (sram_err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a plain word array plus a countdown of clear cycles.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] rdata;
        logic        ready;
        logic        err;
        logic [31:0] lcnt;
        logic [31:0] scnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] mdl_mem [DEPTH];
    int          mdl_init_left = DEPTH;
    logic [31:0] mdl_rdata = '0;
    logic        mdl_err   = 1'b0;
    logic [31:0] mdl_lcnt  = '0;
    logic [31:0] mdl_scnt  = '0;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic en, input logic [3:0] we,
                              input logic [31:0] addr, input logic [31:0] wdata);
        longint off;
        int     idx;
        if (rst) begin
            foreach (mdl_mem[i]) mdl_mem[i] = '0;
            mdl_init_left = DEPTH;
            mdl_rdata     = '0;
            mdl_err       = 1'b0;
            mdl_lcnt      = '0;
            mdl_scnt      = '0;
        end else if (mdl_init_left > 0) begin
            mdl_init_left--;
        end else if (en) begin
            off = longint'({32'd0, addr}) - longint'({32'd0, ADDR_BASE});
            if (off >= 0 && (off / 4) < DEPTH) begin
                idx       = int'(off / 4);
                mdl_rdata = mdl_mem[idx];
                if (we == 4'b0000) begin
                    if (mdl_lcnt != 32'hFFFF_FFFF) mdl_lcnt++;
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (we[b]) mdl_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                    if (mdl_scnt != 32'hFFFF_FFFF) mdl_scnt++;
                end
            end else begin
                mdl_rdata = '0;
                mdl_err   = 1'b1;
            end
        end
    endtask

    // Drive one cycle's inputs at the falling edge and queue what the DUT
    // must show after the following rising edge.
    task automatic apply(input logic rst, input logic en, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        @(negedge clk);
        reset                 = rst;
        u_bus.data_sram_en    = en;
        u_bus.data_sram_we    = we;
        u_bus.data_sram_addr  = addr;
        u_bus.data_sram_wdata = wdata;
        model_step(rst, en, we, addr, wdata);
        e.rdata = mdl_rdata;
        e.ready = (mdl_init_left == 0);
        e.err   = mdl_err;
        e.lcnt  = mdl_lcnt;
        e.scnt  = mdl_scnt;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] addr);
        apply(1'b0, 1'b1, 4'h0, addr, $urandom);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata);
        apply(1'b0, 1'b1, we, addr, wdata);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) apply(1'b1, 1'b1, 4'hF, 32'h10, $urandom);
    endtask

    task automatic random_traffic(input int n);
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        int          sel;
        for (int k = 0; k < n; k++) begin
            en  = ($urandom_range(0, 3) != 0);
            we  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            sel = $urandom_range(0, 19);
            if (sel < 16)
                addr = ADDR_BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            else if (sel == 16)
                addr = ADDR_BASE + 32'((DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
            else if (sel == 17)
                addr = ADDR_BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 7));
            else if (sel == 18)
                addr = ADDR_BASE - 32'($urandom_range(1, 8));
            else
                addr = $urandom;
            apply(1'b0, en, we, addr, $urandom);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: one expected entry per clock, sampled 1 ns after the edge.
    // ------------------------------------------------------------------
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("rdata", u_bus.data_sram_rdata, mon_e.rdata);
            check("sram_ready", 32'(sram_ready), 32'(mon_e.ready));
            check("sram_err", 32'(sram_err), 32'(mon_e.err));
`ifdef DATA_SRAM_STATS_EN
            check("load_cnt", load_cnt, mon_e.lcnt);
            check("store_cnt", store_cnt, mon_e.scnt);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        reset                 = 1'b1;
        u_bus.data_sram_en    = 1'b0;
        u_bus.data_sram_we    = 4'h0;
        u_bus.data_sram_addr  = 32'h0;
        u_bus.data_sram_wdata = 32'h0;

        // Reset, then the clear sweep; a write lands mid-sweep and must be
        // dropped. Ready is checked every cycle of the sweep.
        do_reset(3);
        idle(100);
        wr(32'h20, 4'hF, 32'h1234_5678);
        idle(DEPTH - 101 + 3);

        // Full-word write then read-back, read-first on the write.
        wr(32'h10, 4'hF, 32'hDEAD_BEEF);
        rd(32'h10);
        idle(2);
        // Single-lane merge, then read-after-write.
        wr(32'h10, 4'b0100, 32'h00AA_0000);
        rd(32'h10);
        rd(32'h13);
        // Write dropped during INIT reads back as zero.
        rd(32'h20);
        // Top and first-out-of-range words.
        wr(32'(ADDR_BASE + (DEPTH - 1) * 4), 4'hF, 32'hCAFE_F00D);
        rd(32'(ADDR_BASE + (DEPTH - 1) * 4));
        rd(32'h1000);
        idle(2);
        wr(32'h1000, 4'hF, 32'h5555_5555);
        rd(32'h10);
        wr(32'h14, 4'b1001, 32'hA1B2_C3D4);
        rd(32'h14);

        random_traffic(1500);

        // Reset mid-RUN, then again mid-INIT: the sweep restarts each time.
        do_reset(1);
        idle(300);
        do_reset(2);
        idle(DEPTH + 2);

        // Counter scenario: 3 reads, 2 writes, 1 out-of-range, then reset.
        rd(32'h0);
        wr(32'h4, 4'hF, 32'h0102_0304);
        rd(32'h4);
        wr(32'h8, 4'h3, 32'hFFFF_FFFF);
        rd(32'h8);
        rd(32'hFFFF_FFFC);
        idle(2);
        do_reset(1);
        idle(DEPTH + 1);

        random_traffic(800);
        idle(2);

        // Let the monitor drain the last entries.
        @(posedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter ADDR_BASE, default 32'h0000_0000, byte address of word 0.
REQ-002 Parameter DEPTH_LOG2, default 10, log2 of the word count (DEPTH = 2^DEPTH_LOG2 words of 32 bits).
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_sram_en  input  1  access request this cycle.
REQ-006 data_sram_we  input  4  byte write strobes; 0 means read.
REQ-007 data_sram_addr  input  32  byte address.
REQ-008 data_sram_wdata  input  32  write data, byte lanes aligned to the strobes.
REQ-009 data_sram_rdata  output  32  read data, one cycle after the request.
REQ-010 sram_ready  output  1  high when the block accepts requests (RUN state).
REQ-011 sram_err  output  1  sticky out-of-range access flag.
REQ-012 load_cnt  output  32  accepted read count (only with DATA_SRAM_STATS_EN).
REQ-013 store_cnt  output  32  accepted write count (only with DATA_SRAM_STATS_EN).

Function
REQ-014 The block SHALL have a 2-state FSM: INIT and RUN.
REQ-015 INIT: clear one word per cycle, idx 0..DEPTH-1, via a DEPTH_LOG2-bit counter.
REQ-016 INIT -> RUN on the cycle after idx = DEPTH-1 is cleared; init therefore takes exactly DEPTH cycles.
REQ-017 sram_ready SHALL be 1 only in RUN.
REQ-018 Requests in INIT SHALL be ignored: no write, rdata unchanged, no counter change, no error.
REQ-019 Word index = (data_sram_addr - ADDR_BASE) >> 2, computed in 32 bits; addr[1:0] is ignored for indexing.
REQ-020 Access is in range iff the index < DEPTH; wrap-around of the subtraction SHALL count as out of range.
REQ-021 Read (RUN, en=1, we=0, in range): rdata SHALL equal mem[index] on the next cycle.
REQ-022 Write (RUN, en=1, we!=0, in range): each byte lane i with we[i]=1 SHALL be written from wdata[8i+7:8i]; other lanes are unchanged.
REQ-023 A write SHALL return the pre-write word on rdata the next cycle (read-first).
REQ-024 A read in the cycle after a write to the same index SHALL return the newly written data.
REQ-025 Out of range (RUN, en=1): no write; rdata SHALL be 0 the next cycle; sram_err SHALL set and hold until reset.
REQ-026 When en=0, rdata SHALL hold its previous value.

Reset
REQ-027 reset SHALL force the FSM to INIT, idx=0, data_sram_rdata=0, sram_ready=0, and sram_err=0.
REQ-028 With DATA_SRAM_STATS_EN, reset SHALL clear load_cnt and store_cnt to 0.
REQ-029 reset asserted mid-INIT or mid-RUN SHALL restart the full clear sweep from idx 0.
REQ-030 reset SHALL take priority over any request in the same cycle.

Configuration
REQ-031 With macro DATA_SRAM_STATS_EN defined:
- load_cnt and store_cnt SHALL exist.
- In RUN, each in-range read increments load_cnt by 1, and each in-range write increments store_cnt by 1.
- Both counters SHALL saturate at 32'hFFFF_FFFF.
REQ-032 Without DATA_SRAM_STATS_EN, the ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset, then hold en=0 -> sram_ready rises exactly DEPTH cycles after reset deasserts (1024 at default), rdata=0 throughout.
REQ-034 After init, write addr 0x10, we=4'hF, wdata 0xDEADBEEF; then read 0x10 -> rdata 0x00000000 the cycle after the write, then 0xDEADBEEF the cycle after the read.
REQ-035 Write 0x10, we=4'b0100, wdata 0x00AA0000, over 0xDEADBEEF; then read 0x10 -> 0xDEAABEEF.
REQ-036 Read addr 0x1000 (index 1024, DEPTH=1024) -> rdata 0 next cycle, sram_err=1 and stays 1; a following in-range access still works.
REQ-037 Request a write during INIT; after RUN, read the same address -> rdata 0, store_cnt 0.
REQ-038 With DATA_SRAM_STATS_EN: 3 reads and 2 writes in range plus 1 out-of-range -> load_cnt=3, store_cnt=2; pulse reset -> both 0.
